rx_seg_alloc: RTL and testbench

//  Address/length allocator that schedules the receive DMA engine. Walks the command's PRD list,

---
 rtl/rx_seg_alloc.sv | 194 +++++++++++++++++++
 tb/tb_rx_seg_alloc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_seg_alloc.sv
// rx_seg_alloc: walks a command's PRD list one entry at a time and answers each receive-DMA
// segment request with one contiguous address/length grant. The grant is bounded by the
// requested length, by the bytes left in the current PRD and by C_MAX_SEG. The running
// byte count granted since the last start is reported back to the port.
module rx_seg_alloc #(
  parameter int          C_PRD_IDX_WIDTH = 16,
  parameter logic [13:0] C_MAX_SEG       = 14'h2000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       port2al_start,
  input  logic [C_PRD_IDX_WIDTH-1:0] port2al_prdtl,
  output logic                       al2port_busy,
  output logic [31:0]                al2port_bc,
  output logic                       al2prd_req,
  output logic [C_PRD_IDX_WIDTH-1:0] al2prd_idx,
  input  logic                       prd2al_vld,
  input  logic [31:0]                prd2al_dba,
  input  logic [21:0]                prd2al_dbc,
  input  logic                       rx2al_req,
  input  logic [13:0]                rx2al_len,
  output logic                       al2dh_ack,
  output logic                       al2dh_err,
  output logic [31:0]                al2dh_addr,
  output logic [13:0]                al2dh_len
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READY = 3'd2,
    ST_GRANT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t                     state_r;
  logic [C_PRD_IDX_WIDTH-1:0] idx_r;
  logic [C_PRD_IDX_WIDTH-1:0] prdtl_r;
  logic [22:0]                remain_r;
  logic [31:0]                cur_addr_r;
  // Set once rx2al_req has been seen low; a grant needs a request that was low since the last ack.
  logic                       armed_r;

  logic [13:0]                remain_clip_s;
  logic [13:0]                seg_len_s;
  logic [32:0]                bc_sum_s;
  logic [31:0]                bc_next_s;
  logic                       fresh_req_s;

  assign al2prd_idx  = idx_r;
  assign fresh_req_s = rx2al_req & armed_r;

  // Segment length = min(request, PRD remainder, C_MAX_SEG) and the saturating byte count.
  always_comb begin
    remain_clip_s = C_MAX_SEG;
    seg_len_s     = rx2al_len;
    if (remain_r > {9'd0, C_MAX_SEG}) begin
      remain_clip_s = C_MAX_SEG;
    end else begin
      remain_clip_s = remain_r[13:0];
    end
    if (rx2al_len < remain_clip_s) begin
      seg_len_s = rx2al_len;
    end else begin
      seg_len_s = remain_clip_s;
    end
    bc_sum_s = {1'b0, al2port_bc} + {19'd0, seg_len_s};
    if (bc_sum_s[32]) begin
      bc_next_s = 32'hFFFF_FFFF;
    end else begin
      bc_next_s = bc_sum_s[31:0];
    end
  end

  // Allocator state machine with registered grant, fetch and status outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      prdtl_r      <= '0;
      remain_r     <= 23'd0;
      cur_addr_r   <= 32'd0;
      armed_r      <= 1'b1;
      al2port_busy <= 1'b0;
      al2port_bc   <= 32'd0;
      al2prd_req   <= 1'b0;
      al2dh_ack    <= 1'b0;
      al2dh_err    <= 1'b0;
      al2dh_addr   <= 32'd0;
      al2dh_len    <= 14'd0;
    end else begin
      al2dh_ack <= 1'b0;
      al2dh_err <= 1'b0;
      if (!rx2al_req) begin
        armed_r <= 1'b1;
      end
      if (port2al_start) begin
        // Restart wins over everything, including a PRD arriving in the same cycle.
        idx_r        <= '0;
        prdtl_r      <= port2al_prdtl;
        remain_r     <= 23'd0;
        al2port_bc   <= 32'd0;
        al2port_busy <= 1'b1;
        if (port2al_prdtl != '0) begin
          state_r    <= ST_FETCH;
          al2prd_req <= 1'b1;
        end else begin
          state_r    <= ST_READY;
          al2prd_req <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            al2port_busy <= 1'b0;
            al2prd_req   <= 1'b0;
          end
          ST_FETCH: begin
            if (prd2al_vld) begin
              al2prd_req <= 1'b0;
              idx_r      <= idx_r + C_PRD_IDX_WIDTH'(1);
              cur_addr_r <= prd2al_dba;
              remain_r   <= {1'b0, prd2al_dbc} + 23'd1;
              if (prd2al_dba[0]) begin
                // Misaligned buffer: enter ERR with its entry pulse; a pending request is consumed.
                state_r      <= ST_ERR;
                al2port_busy <= 1'b0;
                al2dh_ack    <= 1'b1;
                al2dh_err    <= 1'b1;
                if (rx2al_req) begin
                  armed_r <= 1'b0;
                end
              end else begin
                state_r <= ST_READY;
              end
            end else begin
              al2prd_req <= 1'b1;
            end
          end
          ST_READY: begin
            if (fresh_req_s) begin
              if ((remain_r == 23'd0) && (idx_r == prdtl_r)) begin
                state_r      <= ST_ERR;
                armed_r      <= 1'b0;
                al2port_busy <= 1'b0;
                al2dh_ack    <= 1'b1;
                al2dh_err    <= 1'b1;
              end else if (remain_r == 23'd0) begin
                // Not reachable in normal flow; fetch rather than grant from an empty PRD.
                state_r    <= ST_FETCH;
                al2prd_req <= 1'b1;
              end else begin
                state_r    <= ST_GRANT;
                armed_r    <= 1'b0;
                al2dh_ack  <= 1'b1;
                al2dh_addr <= cur_addr_r;
                al2dh_len  <= seg_len_s;
                cur_addr_r <= cur_addr_r + {18'd0, seg_len_s};
                remain_r   <= remain_r - {9'd0, seg_len_s};
                al2port_bc <= bc_next_s;
              end
            end
          end
          ST_GRANT: begin
            state_r <= ST_HOLD;
          end
          ST_HOLD: begin
            if ((remain_r == 23'd0) && (idx_r < prdtl_r)) begin
              state_r    <= ST_FETCH;
              al2prd_req <= 1'b1;
            end else begin
              state_r <= ST_READY;
            end
          end
          ST_ERR: begin
            al2port_busy <= 1'b0;
            al2prd_req   <= 1'b0;
            if (fresh_req_s) begin
              armed_r   <= 1'b0;
              al2dh_ack <= 1'b1;
              al2dh_err <= 1'b1;
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            al2port_busy <= 1'b0;
            al2prd_req   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_seg_alloc.sv
// Bench for rx_seg_alloc: a PRD responder model, a receive-DMA requester and a scoreboard of
// expected grants that is checked whenever the allocator pulses al2dh_ack.
module tb_rx_seg_alloc;

  typedef struct packed {
    logic [31:0] addr;
    logic [13:0] len;
    logic        err;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        port2al_start;
  logic [15:0] port2al_prdtl;
  logic        al2port_busy;
  logic [31:0] al2port_bc;
  logic        al2prd_req;
  logic [15:0] al2prd_idx;
  logic        prd2al_vld;
  logic [31:0] prd2al_dba;
  logic [21:0] prd2al_dbc;
  logic        rx2al_req;
  logic [13:0] rx2al_len;
  logic        al2dh_ack;
  logic        al2dh_err;
  logic [31:0] al2dh_addr;
  logic [13:0] al2dh_len;

  logic        resp_vld;
  logic [31:0] resp_dba;
  logic [21:0] resp_dbc;
  logic        inj_vld;
  logic        resp_en;
  int          exp_fetch_idx;
  logic [31:0] prd_dba [4];
  logic [21:0] prd_dbc [4];
  exp_t        sb_q [$];
  int          n_chk;
  int          n_fail;

  assign prd2al_vld = resp_vld | inj_vld;
  assign prd2al_dba = inj_vld ? 32'h0000_5555 : resp_dba;
  assign prd2al_dbc = inj_vld ? 22'd0 : resp_dbc;

  rx_seg_alloc dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .port2al_start (port2al_start),
    .port2al_prdtl (port2al_prdtl),
    .al2port_busy  (al2port_busy),
    .al2port_bc    (al2port_bc),
    .al2prd_req    (al2prd_req),
    .al2prd_idx    (al2prd_idx),
    .prd2al_vld    (prd2al_vld),
    .prd2al_dba    (prd2al_dba),
    .prd2al_dbc    (prd2al_dbc),
    .rx2al_req     (rx2al_req),
    .rx2al_len     (rx2al_len),
    .al2dh_ack     (al2dh_ack),
    .al2dh_err     (al2dh_err),
    .al2dh_addr    (al2dh_addr),
    .al2dh_len     (al2dh_len)
  );

  // 100 MHz clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [15:0] prdtl);
    @(negedge sys_clk);
    port2al_prdtl = prdtl;
    port2al_start = 1'b1;
    exp_fetch_idx = 0;
    @(negedge sys_clk);
    port2al_start = 1'b0;
  endtask

  // Raise a request, wait for its ack, keep req high 'hold' more cycles, then drop it.
  task automatic do_req(input logic [13:0] len, input logic [31:0] eaddr,
                        input logic [13:0] elen, input logic eerr, input int hold);
    exp_t e;
    logic got;
    e.addr = eaddr;
    e.len  = elen;
    e.err  = eerr;
    sb_q.push_back(e);
    @(negedge sys_clk);
    rx2al_req = 1'b1;
    rx2al_len = len;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge sys_clk);
      if (al2dh_ack) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (!got && sb_q.size() > 0) void'(sb_q.pop_back());
    repeat (hold) @(negedge sys_clk);
    rx2al_req = 1'b0;
  endtask

  // PRD fetch unit model: answers each fetch two cycles later from the bench's PRD table.
  initial begin
    resp_vld = 1'b0;
    resp_dba = 32'd0;
    resp_dbc = 22'd0;
    forever begin
      @(negedge sys_clk);
      if (resp_en && al2prd_req && sys_rst_n) begin
        chk("prd_idx", {16'd0, al2prd_idx}, exp_fetch_idx);
        repeat (2) @(negedge sys_clk);
        resp_dba = prd_dba[exp_fetch_idx % 4];
        resp_dbc = prd_dbc[exp_fetch_idx % 4];
        resp_vld = 1'b1;
        @(negedge sys_clk);
        resp_vld = 1'b0;
        exp_fetch_idx = exp_fetch_idx + 1;
      end
    end
  end

  // Scoreboard: every ack pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (al2dh_err && !al2dh_ack) chk("err_without_ack", {31'd0, al2dh_ack}, 32'd1);
      if (al2dh_ack) begin
        if (sb_q.size() == 0) begin
          chk("spurious_ack", {31'd0, al2dh_ack}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ack_err", {31'd0, al2dh_err}, {31'd0, e.err});
          if (!e.err) begin
            chk("ack_addr", al2dh_addr, e.addr);
            chk("ack_len", {18'd0, al2dh_len}, {18'd0, e.len});
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_fetch_idx = 0;
    resp_en = 1'b1;
    inj_vld = 1'b0;
    sys_rst_n = 1'b0;
    port2al_start = 1'b0;
    port2al_prdtl = 16'd0;
    rx2al_req = 1'b0;
    rx2al_len = 14'd0;
    for (int i = 0; i < 4; i++) begin
      prd_dba[i] = 32'd0;
      prd_dbc[i] = 22'd0;
    end
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", {31'd0, al2port_busy}, 32'd0);
    chk("rst_bc", al2port_bc, 32'd0);
    chk("rst_prd_req", {31'd0, al2prd_req}, 32'd0);
    chk("rst_idx", {16'd0, al2prd_idx}, 32'd0);
    chk("rst_ack", {31'd0, al2dh_ack}, 32'd0);
    chk("rst_addr", al2dh_addr, 32'd0);
    sys_rst_n = 1'b1;

    // Single PRD of 0x4000 bytes split into two maximal segments.
    prd_dba[0] = 32'h0000_1000; prd_dbc[0] = 22'h3FFF;
    start_cmd(16'd1);
    chk("t1_busy", {31'd0, al2port_busy}, 32'd1);
    do_req(14'h2000, 32'h0000_1000, 14'h2000, 1'b0, 1);
    do_req(14'h2000, 32'h0000_3000, 14'h2000, 1'b0, 1);
    repeat (3) @(negedge sys_clk);
    chk("t1_bc", al2port_bc, 32'h0000_4000);

    // Two PRDs: the first is exhausted exactly and the second is prefetched.
    prd_dba[0] = 32'h0000_8000; prd_dbc[0] = 22'h00FF;
    prd_dba[1] = 32'h0000_A000; prd_dbc[1] = 22'h0FFF;
    start_cmd(16'd2);
    do_req(14'h2000, 32'h0000_8000, 14'h0100, 1'b0, 1);
    do_req(14'h2000, 32'h0000_A000, 14'h1000, 1'b0, 1);
    repeat (3) @(negedge sys_clk);
    chk("t2_bc", al2port_bc, 32'h0000_1100);
    chk("t2_idx", {16'd0, al2prd_idx}, 32'd2);

    // Empty PRD table: first request errors; busy drops.
    start_cmd(16'd0);
    do_req(14'h0200, 32'd0, 14'd0, 1'b1, 1);
    repeat (2) @(negedge sys_clk);
    chk("t3_busy", {31'd0, al2port_busy}, 32'd0);

    // Recovery, zero-length grant, then exhaustion error with bc frozen.
    prd_dba[0] = 32'h0000_4000; prd_dbc[0] = 22'h00FF;
    start_cmd(16'd1);
    do_req(14'h0000, 32'h0000_4000, 14'h0000, 1'b0, 1);
    chk("t4_bc0", al2port_bc, 32'd0);
    do_req(14'h0200, 32'h0000_4000, 14'h0100, 1'b0, 1);
    chk("t4_bc1", al2port_bc, 32'h0000_0100);
    do_req(14'h0010, 32'd0, 14'd0, 1'b1, 1);
    repeat (2) @(negedge sys_clk);
    chk("t4_bc2", al2port_bc, 32'h0000_0100);
    chk("t4_busy", {31'd0, al2port_busy}, 32'd0);

    // C_MAX_SEG clip and 32-bit address wrap.
    prd_dba[0] = 32'hFFFF_F000; prd_dbc[0] = 22'h2FFF;
    start_cmd(16'd1);
    do_req(14'h3FFF, 32'hFFFF_F000, 14'h2000, 1'b0, 1);
    do_req(14'h3FFF, 32'h0000_1000, 14'h1000, 1'b0, 1);
    repeat (2) @(negedge sys_clk);
    chk("t5_bc", al2port_bc, 32'h0000_3000);

    // Misaligned PRD base: entry pulse, then each fresh request gets ack+err.
    prd_dba[0] = 32'h0000_1001; prd_dbc[0] = 22'h00FF;
    begin
      exp_t e;
      e.addr = 32'd0; e.len = 14'd0; e.err = 1'b1;
      sb_q.push_back(e);
    end
    start_cmd(16'd1);
    repeat (10) @(negedge sys_clk);
    chk("t6_busy", {31'd0, al2port_busy}, 32'd0);
    chk("t6_entry", sb_q.size(), 32'd0);
    do_req(14'h0040, 32'd0, 14'd0, 1'b1, 1);

    // Request held high several cycles after its ack: only one grant.
    prd_dba[0] = 32'h0000_2000; prd_dbc[0] = 22'h0FFF;
    start_cmd(16'd1);
    do_req(14'h0100, 32'h0000_2000, 14'h0100, 1'b0, 3);
    repeat (4) @(negedge sys_clk);
    chk("t7_one_ack", sb_q.size(), 32'd0);
    do_req(14'h0100, 32'h0000_2100, 14'h0100, 1'b0, 1);
    repeat (2) @(negedge sys_clk);
    chk("t7_bc", al2port_bc, 32'h0000_0200);

    // Start during FETCH restarts at index 0 and ignores a coincident PRD valid.
    prd_dba[0] = 32'h0000_3000; prd_dbc[0] = 22'h00FF;
    prd_dba[1] = 32'h0000_6000; prd_dbc[1] = 22'h01FF;
    start_cmd(16'd2);
    do_req(14'h0800, 32'h0000_3000, 14'h0100, 1'b0, 1);
    resp_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("t8_prd_req", {31'd0, al2prd_req}, 32'd1);
    chk("t8_idx1", {16'd0, al2prd_idx}, 32'd1);
    @(negedge sys_clk);
    port2al_prdtl = 16'd2;
    port2al_start = 1'b1;
    inj_vld = 1'b1;
    @(negedge sys_clk);
    port2al_start = 1'b0;
    inj_vld = 1'b0;
    exp_fetch_idx = 0;
    chk("t8_idx0", {16'd0, al2prd_idx}, 32'd0);
    chk("t8_prd_req_kept", {31'd0, al2prd_req}, 32'd1);
    chk("t8_bc", al2port_bc, 32'd0);
    resp_en = 1'b1;
    do_req(14'h0800, 32'h0000_3000, 14'h0100, 1'b0, 1);

    // Asynchronous reset while the grant pulse is high.
    repeat (10) @(negedge sys_clk);
    rx2al_req = 1'b1;
    rx2al_len = 14'h0040;
    @(posedge sys_clk);
    #2;
    chk("t9_ack_pre", {31'd0, al2dh_ack}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("t9_ack", {31'd0, al2dh_ack}, 32'd0);
    chk("t9_busy", {31'd0, al2port_busy}, 32'd0);
    chk("t9_bc", al2port_bc, 32'd0);
    chk("t9_addr", al2dh_addr, 32'd0);
    @(negedge sys_clk);
    rx2al_req = 1'b0;
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("t9_prd_req", {31'd0, al2prd_req}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
